// File: rtl/fft_pkg.sv
// Shared FFT definitions: default datapath sizes, complex sample type and
// the bit-reversal helper used by the serializer, delay line and deserializer.
package fft_pkg;

  localparam int unsigned DATA_DEFAULT  = 9;
  localparam int unsigned ARRAY_DEFAULT = 16;

  typedef struct packed {
    logic signed [DATA_DEFAULT-1:0] re;
    logic signed [DATA_DEFAULT-1:0] im;
  } cplx_t;

  // Buffer occupancy: number of complete vectors waiting to drain.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // Reverse the low iw bits of idx; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned iw);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < iw; i++) begin
      r[i] = idx[iw-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_serializer.sv
// Parallel-to-serial FFT output stage with a two-bank ping-pong buffer.
// One vector is written per input handshake; samples drain one per output
// handshake in natural or bit-reversed bin order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DATA   = DATA_DEFAULT,
  parameter int ARRAY  = ARRAY_DEFAULT,
  parameter int BITREV = 1,
  localparam int IW    = $clog2(ARRAY)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DATA-1:0] in_re [ARRAY-1:0],
  input  logic signed [DATA-1:0] in_im [ARRAY-1:0],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [DATA-1:0] out_re,
  output logic signed [DATA-1:0] out_im,
  output logic [IW-1:0]          out_index,
  output logic                   out_last
);

  occ_t                   occ_q, occ_d;
  logic                   wr_bank, rd_bank;
  logic [IW-1:0]          rd_cnt;
  logic [IW-1:0]          rd_idx;
  logic                   in_fire, out_fire, rd_last;
  logic signed [DATA-1:0] bank_re [2][ARRAY];
  logic signed [DATA-1:0] bank_im [2][ARRAY];

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign rd_last   = (rd_cnt == IW'(ARRAY - 1));

  assign rd_idx    = (BITREV != 0) ? IW'(bitrev(32'(rd_cnt), IW)) : rd_cnt;
  assign out_index = rd_idx;
  assign out_last  = out_valid & rd_last;
  assign out_re    = out_valid ? bank_re[rd_bank][rd_idx] : '0;
  assign out_im    = out_valid ? bank_im[rd_bank][rd_idx] : '0;

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= OCC_EMPTY;
    else     occ_q <= occ_d;
  end

  // Occupancy next state: accept adds a vector, last-sample drain removes one;
  // both in the same cycle leave the count unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire & rd_last})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL)  ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // Bank pointers and read counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      if (in_fire) wr_bank <= ~wr_bank;
      if (out_fire) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt  <= rd_cnt + IW'(1);
        end
      end
    end
  end

  // Vector capture into the write bank; in_ready keeps this off the bank being read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int unsigned j = 0; j < ARRAY; j++) begin
        bank_re[wr_bank][j] <= in_re[j];
        bank_im[wr_bank][j] <= in_im[j];
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: natural and bit-reversed instances
// share all stimulus; expected values come from hand-built tables.
module tb_fft_out_serializer;

  localparam int DATA  = 9;
  localparam int ARRAY = 16;
  localparam int IW    = 4;

  logic clk, rst, in_valid, out_ready;
  logic signed [DATA-1:0] in_re [ARRAY-1:0];
  logic signed [DATA-1:0] in_im [ARRAY-1:0];

  logic                   n_in_ready, n_out_valid, n_out_last;
  logic signed [DATA-1:0] n_out_re, n_out_im;
  logic [IW-1:0]          n_out_index;
  logic                   r_in_ready, r_out_valid, r_out_last;
  logic signed [DATA-1:0] r_out_re, r_out_im;
  logic [IW-1:0]          r_out_index;

  fft_out_serializer #(.DATA(DATA), .ARRAY(ARRAY), .BITREV(0)) dut_nat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_re(n_out_re), .out_im(n_out_im), .out_index(n_out_index), .out_last(n_out_last)
  );

  fft_out_serializer #(.DATA(DATA), .ARRAY(ARRAY), .BITREV(1)) dut_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_re(r_out_re), .out_im(r_out_im), .out_index(r_out_index), .out_last(r_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Bit-reversed order of 0..15, written out by hand.
  int br [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // re[j] = rb + j*rs, im[j] = ib + j*is
  task automatic set_vec(input int rb, input int rs, input int ib, input int is);
    for (int j = 0; j < ARRAY; j++) begin
      in_re[j] = DATA'(rb + j * rs);
      in_im[j] = DATA'(ib + j * is);
    end
  endtask

  int n_got;
  int cyc;
  logic signed [DATA-1:0] h_re, h_im;
  logic [IW-1:0]          h_idx;
  logic                   h_last, stalled;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_vec(0, 0, 0, 0);
    step(); step();

    // Reset state
    chk("rst_in_ready", n_in_ready, 1);
    chk("rst_out_valid", n_out_valid, 0);
    chk("rst_out_last", n_out_last, 0);
    chk("rst_out_index", n_out_index, 0);
    chk("rst_out_re", n_out_re, 0);
    chk("rst_out_im", n_out_im, 0);
    chk("rst_rev_valid", r_out_valid, 0);
    rst = 1'b0;
    step();

    // Natural and bit-reversed order: re[j]=j, im[j]=-j
    set_vec(0, 1, 0, -1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ARRAY; i++) begin
      chk("nat_valid", n_out_valid, 1);
      chk("nat_index", n_out_index, i);
      chk("nat_re", n_out_re, i);
      chk("nat_im", n_out_im, -i);
      chk("nat_last", n_out_last, (i == 15) ? 1 : 0);
      chk("nat_in_ready", n_in_ready, 1);
      chk("rev_index", r_out_index, br[i]);
      chk("rev_re", r_out_re, br[i]);
      chk("rev_im", r_out_im, -br[i]);
      chk("rev_last", r_out_last, (i == 15) ? 1 : 0);
      step();
    end
    chk("nat_drained", n_out_valid, 0);
    chk("nat_drained_re", n_out_re, 0);
    chk("rev_drained", r_out_valid, 0);

    // Back-pressure: re[j]=100+j, im[j]=j-50
    set_vec(100, 1, -50, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_got = 0;
    stalled = 1'b0;
    cyc = 0;
    while (n_got < ARRAY && cyc < 200) begin
      if (stalled) begin
        chk("bp_hold_re", n_out_re, h_re);
        chk("bp_hold_im", n_out_im, h_im);
        chk("bp_hold_idx", n_out_index, h_idx);
        chk("bp_hold_last", n_out_last, h_last);
      end
      out_ready = (((cyc * 7 + 3) % 5) < 3);
      chk("bp_valid", n_out_valid, 1);
      if (out_ready) begin
        chk("bp_index", n_out_index, n_got);
        chk("bp_re", n_out_re, 100 + n_got);
        chk("bp_im", n_out_im, n_got - 50);
        chk("bp_last", n_out_last, (n_got == 15) ? 1 : 0);
        n_got++;
      end
      stalled = ~out_ready;
      h_re = n_out_re; h_im = n_out_im; h_idx = n_out_index; h_last = n_out_last;
      cyc++;
      step();
    end
    chk("bp_count", n_got, ARRAY);
    chk("bp_drained", n_out_valid, 0);
    out_ready = 1'b1;

    // Full condition: A (im=1), B (im=2), C (im=3) on consecutive cycles
    set_vec(0, 1, 1, 0);
    in_valid = 1'b1;
    chk("full_a_ready", n_in_ready, 1);
    step();
    set_vec(20, 1, 2, 0);
    chk("full_b_ready", n_in_ready, 1);
    chk("full_a0_re", n_out_re, 0);
    step();
    set_vec(40, 1, 3, 0);
    for (int i = 1; i < ARRAY; i++) begin
      chk("full_blocked", n_in_ready, 0);
      chk("full_a_re", n_out_re, i);
      chk("full_a_im", n_out_im, 1);
      chk("full_a_last", n_out_last, (i == 15) ? 1 : 0);
      step();
    end
    chk("full_c_ready", n_in_ready, 1);
    chk("full_b0_re", n_out_re, 20);
    chk("full_b0_im", n_out_im, 2);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < ARRAY; i++) begin
      chk("full_b_blocked", n_in_ready, 0);
      chk("full_b_re", n_out_re, 20 + i);
      chk("full_b_im", n_out_im, 2);
      step();
    end
    for (int i = 0; i < ARRAY; i++) begin
      chk("full_c_valid", n_out_valid, 1);
      chk("full_c_re", n_out_re, 40 + i);
      chk("full_c_im", n_out_im, 3);
      chk("full_c_index", n_out_index, i);
      step();
    end
    chk("full_drained", n_out_valid, 0);

    // Extremes: even bins re=-256 im=255, odd bins re=255 im=-256
    for (int j = 0; j < ARRAY; j++) begin
      in_re[j] = (j % 2 == 0) ? -9'sd256 : 9'sd255;
      in_im[j] = (j % 2 == 0) ? 9'sd255 : -9'sd256;
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ARRAY; i++) begin
      chk("ext_nat_re", n_out_re, (i % 2 == 0) ? -256 : 255);
      chk("ext_nat_im", n_out_im, (i % 2 == 0) ? 255 : -256);
      chk("ext_rev_re", r_out_re, (br[i] % 2 == 0) ? -256 : 255);
      chk("ext_rev_im", r_out_im, (br[i] % 2 == 0) ? 255 : -256);
      step();
    end

    // Reset mid-vector after 5 samples
    set_vec(60, 1, 0, -1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mid_re", n_out_re, 60 + i);
      step();
    end
    chk("mid_pre_rst_idx", n_out_index, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", n_out_valid, 0);
    chk("mid_rst_ready", n_in_ready, 1);
    chk("mid_rst_index", n_out_index, 0);
    chk("mid_rst_re", n_out_re, 0);
    chk("mid_rst_rev_valid", r_out_valid, 0);
    set_vec(0, 3, 0, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < ARRAY; i++) begin
      chk("post_index", n_out_index, i);
      chk("post_re", n_out_re, 3 * i);
      chk("post_im", n_out_im, i);
      chk("post_rev_re", r_out_re, 3 * br[i]);
      step();
    end
    chk("post_drained", n_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
